// File: rtl/knight_pkg.sv
// knight_pkg: shared scanner sequence definitions (direction codes, decoder states, next-pattern and validity functions)
package knight_pkg;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam int MAX_W = 32;
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_LOCK} state_t;
  typedef struct packed {
    logic [MAX_W-1:0] pat;
    logic dir;
  } step_t;
  // Patterns are zero-extended to MAX_W; w is the live LED width (3..32).
  function automatic step_t knight_next(input logic [MAX_W-1:0] p, input logic d, input int w);
    logic [MAX_W-1:0] top = MAX_W'(1) << (w - 1);
    logic [MAX_W-1:0] sec = MAX_W'(1) << (w - 2);
    logic [MAX_W-1:0] mask = MAX_W'((64'h1 << w) - 64'h1);
    logic hi = (p & (top | sec)) == top;
    step_t r;
    if (d == DIR_UP) begin
      r.pat = p == '0 ? MAX_W'(1) : p == MAX_W'(1) ? MAX_W'(3) : hi ? '0 : (p << 1) & mask;
      r.dir = hi ? DIR_DOWN : DIR_UP;
    end else begin
      r.pat = p == '0 ? top : hi ? p | sec : p == MAX_W'(1) ? '0 : p >> 1;
      r.dir = p == MAX_W'(1) ? DIR_UP : DIR_DOWN;
    end
    return r;
  endfunction
  // Valid: blank, single bit at either end, or exactly one pair of adjacent lit bits.
  function automatic logic knight_valid(input logic [MAX_W-1:0] p, input int w);
    logic [MAX_W-1:0] q = p & (p >> 1);
    return p == '0 || p == MAX_W'(1) || p == (MAX_W'(1) << (w - 1)) ||
           (q != '0 && (q & (q - MAX_W'(1))) == '0 && p == (q | (q << 1)));
  endfunction
endpackage

// File: rtl/knight_decoder_if.sv
// knight_decoder_if: LED observation bus and reconstructed scanner status
//   master: drives led_in, stall_limit, clear_err; reads status
//   slave : the decoder, reads led_in/controls, drives locked, dir, head, blank,
//           step, cycle_done, error, err_count, stalled
interface knight_decoder_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] led_in;
  logic [23:0] stall_limit;
  logic clear_err;
  logic locked;
  logic dir;
  logic [$clog2(WIDTH)-1:0] head;
  logic blank;
  logic step;
  logic cycle_done;
  logic error;
  logic [15:0] err_count;
  logic stalled;
  modport master(output led_in, stall_limit, clear_err,
                 input locked, dir, head, blank, step, cycle_done, error, err_count, stalled);
  modport slave(input led_in, stall_limit, clear_err,
                output locked, dir, head, blank, step, cycle_done, error, err_count, stalled);
endinterface

// File: rtl/bit_sync.sv
// bit_sync: STAGES-deep flop chain per bit on clk_src; STAGES=0 passes d straight through
//   clk_src, reset_n (async active-low), d: raw input, q: synchronized output
module bit_sync #(
  parameter int WIDTH = 8,
  parameter int STAGES = 2
) (
  input  logic clk_src,
  input  logic reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (STAGES == 0) begin : g_wire
    assign q = d;
  end else begin : g_ff
    logic [WIDTH-1:0] ff [STAGES];
    always_ff @(posedge clk_src or negedge reset_n)
      if (!reset_n) begin
        for (int i = 0; i < STAGES; i++) ff[i] <= '0;
      end else begin
        ff[0] <= d;
        for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
      end
    assign q = ff[STAGES-1];
  end
endmodule

// File: rtl/knight_decoder.sv
// knight_decoder: tracks a knight-rider LED scanner and reconstructs lock, direction, head, pulses, errors, stall
//   clk_src, reset_n (async active-low); bus (slave): led_in/stall_limit/clear_err in,
//   locked/dir/head/blank/step/cycle_done/error/err_count/stalled out (all registered)
module knight_decoder
  import knight_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic clk_src,
  input logic reset_n,
  knight_decoder_if.slave bus
);
  localparam int HW = $clog2(WIDTH);
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] ref_pat;
  state_t state;
  logic [23:0] stall_cnt;
  step_t nu, nd;
  logic chg, valid, mu, md, accept, bad, acc_dir, hold;
  logic [23:0] cnt_inc;
  logic [HW-1:0] hi_i, lo_i;
  bit_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk_src(clk_src),
    .reset_n(reset_n),
    .d(bus.led_in),
    .q(s)
  );
  always_comb begin
    nu = knight_next(MAX_W'(ref_pat), DIR_UP, WIDTH);
    nd = knight_next(MAX_W'(ref_pat), DIR_DOWN, WIDTH);
    chg = s != ref_pat;
    valid = knight_valid(MAX_W'(s), WIDTH);
    mu = MAX_W'(s) == nu.pat;
    md = MAX_W'(s) == nd.pat;
    // next(p,1) != next(p,0) for every valid p, so mu and md never both hold
    accept = chg && (state == S_ONE ? (mu || md) : state == S_LOCK && (bus.dir ? mu : md));
    bad = chg && state == S_LOCK && !(bus.dir ? mu : md);
    acc_dir = (state == S_LOCK ? bus.dir : mu) ? nu.dir : nd.dir;
    hold = state == S_LOCK && !chg;
    cnt_inc = &stall_cnt ? stall_cnt : stall_cnt + 24'd1;
    hi_i = '0;
    lo_i = '0;
    for (int i = 0; i < WIDTH; i++) if (s[i]) hi_i = HW'(i);
    for (int i = WIDTH - 1; i >= 0; i--) if (s[i]) lo_i = HW'(i);
  end
  // While locked, bus.dir doubles as the tracked scan direction.
  always_ff @(posedge clk_src or negedge reset_n)
    if (!reset_n) begin
      state <= S_EMPTY;
      ref_pat <= '0;
      stall_cnt <= '0;
      bus.locked <= 1'b0;
      bus.dir <= 1'b0;
      bus.head <= '0;
      bus.blank <= 1'b0;
      bus.step <= 1'b0;
      bus.cycle_done <= 1'b0;
      bus.error <= 1'b0;
      bus.err_count <= '0;
      bus.stalled <= 1'b0;
    end else begin
      bus.step <= accept;
      bus.error <= bad;
      bus.cycle_done <= accept && state == S_LOCK && ref_pat == WIDTH'(1) && !bus.dir && s == '0;
      stall_cnt <= hold ? cnt_inc : '0;
      bus.stalled <= hold && (bus.stalled || (bus.stall_limit != '0 && cnt_inc == bus.stall_limit));
      bus.err_count <= bad ? (bus.clear_err ? 16'd1 : bus.err_count == 16'hFFFF ? 16'hFFFF : bus.err_count + 16'd1)
                           : bus.clear_err ? 16'd0 : bus.err_count;
      if (accept) begin
        state <= S_LOCK;
        ref_pat <= s;
        bus.locked <= 1'b1;
        bus.dir <= acc_dir;
        bus.head <= s == '0 ? '0 : acc_dir ? hi_i : lo_i;
        bus.blank <= s == '0;
      end else if (state == S_EMPTY || chg) begin
        state <= valid ? S_ONE : S_EMPTY;
        if (valid) ref_pat <= s;
        bus.locked <= 1'b0;
        bus.dir <= 1'b0;
        bus.head <= '0;
        bus.blank <= 1'b0;
      end
    end
endmodule

// File: tb/tb_knight_decoder.sv
// tb_knight_decoder: directed checks of the knight decoder with WIDTH=8, SYNC_STAGES=2
module tb_knight_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int n_step = 0;
  int n_cd = 0;
  int n_err = 0;
  logic st3;
  int base;
  logic [7:0] per [20] = '{8'h00, 8'h01, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h80,
                           8'h00, 8'h80, 8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h01};
  int hd [20] = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 7, 0, 7, 6, 5, 4, 3, 2, 1, 0, 0};
  knight_decoder_if #(.WIDTH(8)) bus ();
  knight_decoder #(.WIDTH(8), .SYNC_STAGES(2)) dut (.clk_src(clk), .reset_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [7:0] p);
    bus.led_in = p;
    st3 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      if (k == 3) st3 = bus.step;
      n_step += int'(bus.step);
      n_cd += int'(bus.cycle_done);
      n_err += int'(bus.error);
    end
  endtask
  initial begin
    bus.led_in = 8'h00;
    bus.stall_limit = 24'd0;
    bus.clear_err = 1'b0;
    tick(3);
    chk("rst_locked", bus.locked, 0);
    chk("rst_head", bus.head, 0);
    chk("rst_err_count", bus.err_count, 0);
    chk("rst_step", bus.step, 0);
    chk("rst_stalled", bus.stalled, 0);
    rst_n = 1'b1;
    // full period twice
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 20; i++) begin
        drive(per[i]);
        if (r == 0 && i == 0) chk("t1_first_nostep", st3, 0);
        else begin
          chk($sformatf("t1_step_%0d_%0d", r, i), st3, 1);
          chk($sformatf("t1_locked_%0d_%0d", r, i), bus.locked, 1);
          chk($sformatf("t1_dir_%0d_%0d", r, i), bus.dir, i < 10);
          chk($sformatf("t1_head_%0d_%0d", r, i), bus.head, hd[i]);
          chk($sformatf("t1_blank_%0d_%0d", r, i), bus.blank, i == 0 || i == 10);
        end
      end
    drive(8'h00);
    chk("t1_final_dir", bus.dir, 1);
    chk("t1_final_blank", bus.blank, 1);
    chk("t1_steps", n_step, 40);
    chk("t1_cycle_done", n_cd, 2);
    chk("t1_errors", n_err, 0);
    chk("t1_err_count", bus.err_count, 0);
    // out-of-sequence step 0C -> 30
    drive(8'h01);
    drive(8'h03);
    drive(8'h06);
    drive(8'h0C);
    base = n_err;
    drive(8'h30);
    chk("t2_error_pulse", n_err - base, 1);
    chk("t2_err_count", bus.err_count, 1);
    chk("t2_unlocked", bus.locked, 0);
    chk("t2_nostep", st3, 0);
    drive(8'h60);
    chk("t2_relock", bus.locked, 1);
    chk("t2_relock_dir", bus.dir, 1);
    chk("t2_relock_head", bus.head, 6);
    // stall while holding 06 on the down pass
    drive(8'hC0);
    drive(8'h80);
    drive(8'h00);
    drive(8'h80);
    drive(8'hC0);
    drive(8'h60);
    drive(8'h30);
    drive(8'h18);
    drive(8'h0C);
    bus.stall_limit = 24'd10;
    bus.led_in = 8'h06;
    tick(3);
    chk("t3_step", bus.step, 1);
    tick(9);
    chk("t3_not_yet_stalled", bus.stalled, 0);
    tick(1);
    chk("t3_stalled", bus.stalled, 1);
    chk("t3_locked_stalled", bus.locked, 1);
    tick(5);
    chk("t3_stalled_held", bus.stalled, 1);
    bus.led_in = 8'h03;
    tick(2);
    chk("t3_stalled_until_step", bus.stalled, 1);
    tick(1);
    chk("t3_stall_cleared", bus.stalled, 0);
    chk("t3_step_after", bus.step, 1);
    chk("t3_locked_after", bus.locked, 1);
    chk("t3_dir_after", bus.dir, 0);
    tick(2);
    bus.stall_limit = 24'd0;
    // invalid pattern, then seed from 00 and lock down on 80
    bus.led_in = 8'h00;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    base = n_err;
    drive(8'h5A);
    chk("t4_invalid_unlocked", bus.locked, 0);
    drive(8'h00);
    chk("t4_seed_unlocked", bus.locked, 0);
    drive(8'h80);
    chk("t4_locked", bus.locked, 1);
    chk("t4_dir", bus.dir, 0);
    chk("t4_head", bus.head, 7);
    chk("t4_no_error", n_err - base, 0);
    chk("t4_err_count", bus.err_count, 0);
    // saturation and clear-with-error
    force bus.err_count = 16'hFFFD;
    #1;
    release bus.err_count;
    drive(8'h03);
    chk("t5_count_fffe", bus.err_count, 16'hFFFE);
    drive(8'h01);
    chk("t5_relock1", bus.locked, 1);
    drive(8'h06);
    chk("t5_count_ffff", bus.err_count, 16'hFFFF);
    drive(8'h03);
    chk("t5_relock2", bus.locked, 1);
    drive(8'h0C);
    chk("t5_saturated", bus.err_count, 16'hFFFF);
    drive(8'h18);
    chk("t5_relock3_dir", bus.dir, 1);
    bus.led_in = 8'h03;
    tick(2);
    bus.clear_err = 1'b1;
    tick(1);
    bus.clear_err = 1'b0;
    chk("t5_clear_error_pulse", bus.error, 1);
    chk("t5_clear_with_error", bus.err_count, 1);
    tick(2);
    // reset mid-pass at C0
    drive(8'h06);
    drive(8'h0C);
    drive(8'h18);
    drive(8'h30);
    drive(8'h60);
    drive(8'hC0);
    chk("t6_pre_locked", bus.locked, 1);
    chk("t6_pre_dir", bus.dir, 1);
    chk("t6_pre_head", bus.head, 7);
    rst_n = 1'b0;
    #1;
    chk("t6_async_locked", bus.locked, 0);
    chk("t6_async_dir", bus.dir, 0);
    chk("t6_async_head", bus.head, 0);
    chk("t6_async_err_count", bus.err_count, 0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    chk("t6_seeded_unlocked", bus.locked, 0);
    drive(8'h80);
    chk("t6_relocked", bus.locked, 1);
    chk("t6_relock_dir", bus.dir, 1);
    chk("t6_relock_head", bus.head, 7);
    drive(8'h00);
    chk("t6_turn_dir", bus.dir, 0);
    chk("t6_turn_blank", bus.blank, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
